// File: rtl/ni_pkg.sv
// rtl/ni_pkg.sv - flit format, error codes and receiver state shared by the NI blocks
package ni_pkg;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_RSVD   = 2'b11
    } flit_type_t;

    localparam int TYPE_HI = 47;
    localparam int TYPE_LO = 46;
    localparam int SRC_HI  = 45;
    localparam int SRC_LO  = 38;
    localparam int DEST_HI = 37;
    localparam int DEST_LO = 30;
    localparam int LEN_HI  = 29;
    localparam int LEN_LO  = 22;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 0;
    localparam int DATA_W  = DATA_HI - DATA_LO + 1;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ADDR  = 2'b01;
    localparam logic [1:0] ERR_LEN   = 2'b10;
    localparam logic [1:0] ERR_PROTO = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RECV = 2'b01,
        ST_DROP = 2'b10
    } rx_state_t;

    function automatic logic len_in_range(input logic [7:0] len, input int max_len);
        return (len != 8'd0) && (int'({1'b0, len}) <= max_len);
    endfunction

endpackage

// File: rtl/ni_wr_stage.sv
// rtl/ni_wr_stage.sv - single-entry SRAM write register, held until sram_ready, flushable
module ni_wr_stage
    import ni_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              flush,
    input  logic              sram_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    // A load only arrives when the entry is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_addr  <= load_addr;
            out_data  <= load_data;
        end else if (sram_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ni_flit_receiver.sv
// rtl/ni_flit_receiver.sv - receive-side NI: checks packets, writes payload into an SRAM ring
module ni_flit_receiver
    import ni_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [47:0]       flit_in,
    input  logic              flit_valid,
    output logic              flit_ready,
    input  logic [7:0]        local_addr,
    output logic              sram_wr_en,
    output logic [ADDR_W-1:0] sram_wr_addr,
    output logic [15:0]       sram_wr_data,
    input  logic              sram_ready,
    output logic              pkt_done,
    output logic [7:0]        pkt_src,
    output logic [7:0]        pkt_len,
    output logic              pkt_error,
    output logic [1:0]        err_code
);

    rx_state_t         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] pkt_start_q, pkt_start_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;

    flit_type_t        ftype;
    logic [7:0]        hdr_src, hdr_dest, hdr_len;
    logic [1:0]        hdr_err;
    logic              accept, last_word, take_hdr;
    logic              wr_load, wr_flush, done_d, err_d;
    logic [1:0]        code_d;
    logic              out_valid;
    logic              unused_bits;

    assign ftype       = flit_type_t'(flit_in[TYPE_HI:TYPE_LO]);
    assign hdr_src     = flit_in[SRC_HI:SRC_LO];
    assign hdr_dest    = flit_in[DEST_HI:DEST_LO];
    assign hdr_len     = flit_in[LEN_HI:LEN_LO];
    assign unused_bits = ^flit_in[LEN_LO-1:DATA_HI+1];

    assign hdr_err = (hdr_dest != local_addr)          ? ERR_ADDR :
                     !len_in_range(hdr_len, MAX_LEN)   ? ERR_LEN  : ERR_NONE;

    // Ready depends only on registered state and sram_ready, never on flit_valid.
    assign flit_ready = !reset && ((state_q == ST_DROP) || !(out_valid && !sram_ready));
    assign accept     = flit_valid && flit_ready;
    assign last_word  = (({1'b0, cnt_q} + 9'd1) == {1'b0, len_q});

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        pkt_start_d = pkt_start_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wr_load     = 1'b0;
        wr_flush    = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = ERR_NONE;
        take_hdr    = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_RECV: begin
                    unique case (ftype)
                        FLIT_BODY, FLIT_TAIL: begin
                            if (last_word == (ftype == FLIT_TAIL)) begin
                                wr_load  = 1'b1;
                                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                                cnt_d    = cnt_q + 8'd1;
                                if (ftype == FLIT_TAIL) begin
                                    done_d  = 1'b1;
                                    state_d = ST_IDLE;
                                end
                            end else begin
                                err_d    = 1'b1;
                                code_d   = ERR_LEN;
                                wr_ptr_d = pkt_start_q;
                                wr_flush = 1'b1;
                                state_d  = (ftype == FLIT_TAIL) ? ST_IDLE : ST_DROP;
                            end
                        end
                        default: begin
                            err_d    = 1'b1;
                            code_d   = ERR_PROTO;
                            wr_ptr_d = pkt_start_q;
                            wr_flush = 1'b1;
                            state_d  = ST_DROP;
                            take_hdr = (ftype == FLIT_HEADER);
                        end
                    endcase
                end
                ST_DROP: begin
                    if (ftype == FLIT_HEADER) begin
                        take_hdr = 1'b1;
                    end else if (ftype == FLIT_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (ftype == FLIT_HEADER) begin
                        take_hdr = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_PROTO;
                    end
                end
            endcase
        end

        // The new packet starts at the (possibly rewound) pointer; an earlier protocol error wins the code.
        if (take_hdr) begin
            if (hdr_err == ERR_NONE) begin
                state_d     = ST_RECV;
                len_d       = hdr_len;
                cnt_d       = 8'd0;
                pkt_start_d = wr_ptr_d;
            end else begin
                state_d = ST_DROP;
                if (!err_d) begin
                    err_d  = 1'b1;
                    code_d = hdr_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            pkt_start_q <= '0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            pkt_done    <= 1'b0;
            pkt_len     <= 8'd0;
            pkt_src     <= 8'd0;
            pkt_error   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            pkt_start_q <= pkt_start_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            pkt_done    <= done_d;
            pkt_error   <= err_d;
            err_code    <= code_d;
            if (done_d) begin
                pkt_len <= len_q;
            end
            if (accept && (ftype == FLIT_HEADER)) begin
                pkt_src <= hdr_src;
            end
        end
    end

    ni_wr_stage #(
        .ADDR_W(ADDR_W)
    ) u_wr_stage (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_load),
        .load_addr  (wr_ptr_q),
        .load_data  (flit_in[DATA_HI:DATA_LO]),
        .flush      (wr_flush),
        .sram_ready (sram_ready),
        .out_valid  (out_valid),
        .out_addr   (sram_wr_addr),
        .out_data   (sram_wr_data)
    );

    assign sram_wr_en = out_valid;

endmodule

// File: tb/tb_ni_flit_receiver.sv
// tb/tb_ni_flit_receiver.sv - directed self-checking bench for ni_flit_receiver
module tb_ni_flit_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] flit_in;
    logic        flit_valid;
    logic        flit_ready;
    logic [7:0]  local_addr;
    logic        sram_wr_en;
    logic [3:0]  sram_wr_addr;
    logic [15:0] sram_wr_data;
    logic        sram_ready;
    logic        pkt_done;
    logic [7:0]  pkt_src;
    logic [7:0]  pkt_len;
    logic        pkt_error;
    logic [1:0]  err_code;

    int passed = 0;
    int total  = 0;

    logic [3:0]  wa[$];
    logic [15:0] wd[$];
    logic [1:0]  ec[$];
    int          done_n = 0;
    int          both_n = 0;
    logic        done_wr;
    logic [3:0]  done_addr;

    always #5 clk = ~clk;

    ni_flit_receiver #(
        .ADDR_W  (4),
        .MAX_LEN (255)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flit_in      (flit_in),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .local_addr   (local_addr),
        .sram_wr_en   (sram_wr_en),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .sram_ready   (sram_ready),
        .pkt_done     (pkt_done),
        .pkt_src      (pkt_src),
        .pkt_len      (pkt_len),
        .pkt_error    (pkt_error),
        .err_code     (err_code)
    );

    always @(negedge clk) begin
        if (sram_wr_en && sram_ready) begin
            wa.push_back(sram_wr_addr);
            wd.push_back(sram_wr_data);
        end
        if (pkt_error) ec.push_back(err_code);
        if (pkt_done) begin
            done_n++;
            done_wr   = sram_wr_en;
            done_addr = sram_wr_addr;
        end
        if (pkt_done && pkt_error) both_n++;
    end

    function automatic logic [47:0] hdr(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
        return {2'b00, s, d, l, 22'd0};
    endfunction

    function automatic logic [47:0] bdy(input logic [15:0] w);
        return {2'b01, 30'd0, w};
    endfunction

    function automatic logic [47:0] tl(input logic [15:0] w);
        return {2'b10, 30'd0, w};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_logs();
        wa.delete();
        wd.delete();
        ec.delete();
        done_n = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the flit until it is accepted (bounded).
    task automatic send(input logic [47:0] f);
        int n;
        n = 0;
        flit_in    = f;
        flit_valid = 1'b1;
        @(negedge clk);
        while (!flit_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!flit_ready) check("send_timeout", flit_ready, 1'b1);
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [3:0] a, input logic [15:0] d);
        logic [19:0] obs;
        obs = (idx < wa.size()) ? {wa[idx], wd[idx]} : 20'hxxxxx;
        check(tag, obs, {a, d});
    endtask

    task automatic expect_err(input string tag, input int idx, input logic [1:0] c);
        logic [1:0] obs;
        obs = (idx < ec.size()) ? ec[idx] : 2'bxx;
        check(tag, obs, c);
    endtask

    initial begin
        reset      = 1'b1;
        flit_in    = '0;
        flit_valid = 1'b0;
        sram_ready = 1'b1;
        local_addr = 8'h05;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", flit_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", flit_ready, 1'b1);
        check("outs_after_reset",
              {sram_wr_en, sram_wr_addr, sram_wr_data, pkt_done, pkt_src, pkt_len, pkt_error, err_code}, 64'd0);
        @(posedge clk);
        #1;

        // 1: good 3-word packet from 0x02
        clear_logs();
        send(hdr(8'h02, 8'h05, 8'd3));
        send(bdy(16'hAAAA));
        send(bdy(16'hBBBB));
        send(tl(16'hCCCC));
        idle(3);
        check("t1_nwr", wa.size(), 3);
        expect_wr("t1_wr0", 0, 4'd0, 16'hAAAA);
        expect_wr("t1_wr1", 1, 4'd1, 16'hBBBB);
        expect_wr("t1_wr2", 2, 4'd2, 16'hCCCC);
        check("t1_done", done_n, 1);
        check("t1_done_with_wr", {done_wr, done_addr}, {1'b1, 4'd2});
        check("t1_len_src", {pkt_len, pkt_src}, {8'd3, 8'h02});
        check("t1_nerr", ec.size(), 0);

        // 2: stray body in IDLE, misaddressed packet dropped, next packet at wr_ptr=3
        clear_logs();
        send(bdy(16'hDEAD));
        send(hdr(8'h02, 8'h07, 8'd3));
        send(bdy(16'h1234));
        send(bdy(16'h5678));
        send(tl(16'h9ABC));
        idle(2);
        check("t2_nerr", ec.size(), 2);
        expect_err("t2_err_stray", 0, 2'b11);
        expect_err("t2_err_addr", 1, 2'b01);
        check("t2_nwr_drop", wa.size(), 0);
        send(hdr(8'h03, 8'h05, 8'd1));
        send(tl(16'h1111));
        idle(2);
        expect_wr("t2_wr_next", 0, 4'd3, 16'h1111);
        check("t2_done", done_n, 1);

        // 3: short packet (tail early) then packet reuses the base
        clear_logs();
        send(hdr(8'h04, 8'h05, 8'd3));
        send(bdy(16'h3333));
        send(tl(16'h4444));
        idle(2);
        check("t3_nwr_short", wa.size(), 1);
        expect_wr("t3_wr_body", 0, 4'd4, 16'h3333);
        check("t3_nerr", ec.size(), 1);
        expect_err("t3_err_len", 0, 2'b10);
        check("t3_no_done", done_n, 0);
        send(hdr(8'h04, 8'h05, 8'd1));
        send(tl(16'h5555));
        idle(2);
        expect_wr("t3_wr_rewind", 1, 4'd4, 16'h5555);
        check("t3_done_len", {done_n[7:0], pkt_len}, {8'd1, 8'd1});

        // 3b: body where the tail is due, zero-length header
        clear_logs();
        send(hdr(8'h04, 8'h05, 8'd1));
        send(bdy(16'h9999));
        send(tl(16'hAAAA));
        send(hdr(8'h04, 8'h05, 8'd0));
        send(tl(16'hBBBB));
        idle(2);
        check("t3b_nwr", wa.size(), 0);
        check("t3b_nerr", ec.size(), 2);
        expect_err("t3b_err_long", 0, 2'b10);
        expect_err("t3b_err_zero", 1, 2'b10);

        // 4: header interrupts a packet; new packet lands at the old base
        clear_logs();
        send(hdr(8'h06, 8'h05, 8'd2));
        send(bdy(16'h6666));
        send(hdr(8'h07, 8'h05, 8'd1));
        send(tl(16'h7777));
        idle(2);
        check("t4_nerr", ec.size(), 1);
        expect_err("t4_err_proto", 0, 2'b11);
        expect_wr("t4_wr_abort", 0, 4'd5, 16'h6666);
        expect_wr("t4_wr_new", 1, 4'd5, 16'h7777);
        check("t4_done_src_len", {done_n[7:0], pkt_src, pkt_len}, {8'd1, 8'h07, 8'd1});

        // 5: SRAM backpressure for 4 cycles
        clear_logs();
        send(hdr(8'h08, 8'h05, 8'd3));
        sram_ready = 1'b0;
        send(bdy(16'h8001));
        flit_in    = bdy(16'h8002);
        flit_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t5_stall%0d", i),
                  {flit_ready, sram_wr_en, sram_wr_addr, sram_wr_data}, {1'b0, 1'b1, 4'd6, 16'h8001});
        end
        @(posedge clk);
        #1;
        sram_ready = 1'b1;
        send(bdy(16'h8002));
        send(tl(16'h8003));
        idle(2);
        check("t5_nwr", wa.size(), 3);
        expect_wr("t5_wr0", 0, 4'd6, 16'h8001);
        expect_wr("t5_wr1", 1, 4'd7, 16'h8002);
        expect_wr("t5_wr2", 2, 4'd8, 16'h8003);
        check("t5_done", done_n, 1);

        // 6: advance wr_ptr to 14, then a 4-word packet wraps the ring
        send(hdr(8'h09, 8'h05, 8'd5));
        for (int i = 0; i < 4; i++) send(bdy(16'h0900 + 16'(i)));
        send(tl(16'h0904));
        idle(2);
        clear_logs();
        send(hdr(8'h0A, 8'h05, 8'd4));
        send(bdy(16'hA000));
        send(bdy(16'hA001));
        send(bdy(16'hA002));
        send(tl(16'hA003));
        idle(2);
        expect_wr("t6_wr14", 0, 4'd14, 16'hA000);
        expect_wr("t6_wr15", 1, 4'd15, 16'hA001);
        expect_wr("t6_wr0", 2, 4'd0, 16'hA002);
        expect_wr("t6_wr1", 3, 4'd1, 16'hA003);
        check("t6_done_len", {done_n[7:0], pkt_len}, {8'd1, 8'd4});

        // reset with a packet open and a write pending
        clear_logs();
        send(hdr(8'h0B, 8'h05, 8'd4));
        sram_ready = 1'b0;
        send(bdy(16'hB001));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_outs_in_reset",
              {flit_ready, sram_wr_en, sram_wr_addr, sram_wr_data, pkt_done, pkt_src, pkt_len, pkt_error, err_code},
              64'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        sram_ready = 1'b1;
        send(hdr(8'h0C, 8'h05, 8'd1));
        send(tl(16'hC0C0));
        idle(2);
        check("t6_nwr_after_reset", wa.size(), 1);
        expect_wr("t6_wr_ptr0", 0, 4'd0, 16'hC0C0);
        check("t6_nerr_after_reset", ec.size(), 0);
        check("never_done_and_error", both_n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
